// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: controller states, big-sigma rotation amounts,
// and helpers for locating word i inside an eight-word packed vector
// (word 0 lives in the most significant bits).
package sha2_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_e;

  // SHA-256 big-sigma rotations
  localparam int S0_32_A = 2;
  localparam int S0_32_B = 13;
  localparam int S0_32_C = 22;
  localparam int S1_32_A = 6;
  localparam int S1_32_B = 11;
  localparam int S1_32_C = 25;

  // SHA-512 big-sigma rotations
  localparam int S0_64_A = 28;
  localparam int S0_64_B = 34;
  localparam int S0_64_C = 39;
  localparam int S1_64_A = 14;
  localparam int S1_64_B = 18;
  localparam int S1_64_C = 41;

  function automatic int wordHi(input int idx, input int w);
    return (8 - idx) * w - 1;
  endfunction

  function automatic int wordLo(input int idx, input int w);
    return (7 - idx) * w;
  endfunction

  // Rotate right within a w-bit word held in the low bits of a 64-bit value.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x >> n) | (x << (w - n))) & mask;
  endfunction

  function automatic logic [63:0] bigSigma0(input logic [63:0] x, input int w);
    if (w == 64) return rotr(x, S0_64_A, 64) ^ rotr(x, S0_64_B, 64) ^ rotr(x, S0_64_C, 64);
    else         return rotr(x, S0_32_A, 32) ^ rotr(x, S0_32_B, 32) ^ rotr(x, S0_32_C, 32);
  endfunction

  function automatic logic [63:0] bigSigma1(input logic [63:0] x, input int w);
    if (w == 64) return rotr(x, S1_64_A, 64) ^ rotr(x, S1_64_B, 64) ^ rotr(x, S1_64_C, 64);
    else         return rotr(x, S1_32_A, 32) ^ rotr(x, S1_32_B, 32) ^ rotr(x, S1_32_C, 32);
  endfunction

endpackage

// File: rtl/sha2_state_regs_if.sv
// Block-level handshake between the schedule/constant unit, the controller
// that starts blocks, and the SHA-2 state register bank.
interface sha2_state_regs_if #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
);
  localparam int RW = $clog2(ROUNDS);

  logic                  start;
  logic                  first_block;
  logic [8*WORD_W-1:0]   iv_i;
  logic [WORD_W-1:0]     kw_i;
  logic                  kw_valid_i;
  logic [RW-1:0]         round_o;
  logic                  busy_o;
  logic                  done_o;
  logic [8*WORD_W-1:0]   digest_o;

  modport master (
    output start, first_block, iv_i, kw_i, kw_valid_i,
    input  round_o, busy_o, done_o, digest_o
  );

  modport slave (
    input  start, first_block, iv_i, kw_i, kw_valid_i,
    output round_o, busy_o, done_o, digest_o
  );
endinterface

// File: rtl/sha2_round.sv
// One SHA-2 compression round: computes T1/T2 and the shifted working
// variables a..h from the current ones plus the precomputed K_t+W_t.
module sha2_round
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [8*WORD_W-1:0] vars_i,
  input  logic [WORD_W-1:0]   kw_i,
  output logic [8*WORD_W-1:0] vars_o
);
  logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
  logic [WORD_W-1:0] sig0, sig1, ch, maj, t1, t2;

  assign a = vars_i[wordHi(0, WORD_W) -: WORD_W];
  assign b = vars_i[wordHi(1, WORD_W) -: WORD_W];
  assign c = vars_i[wordHi(2, WORD_W) -: WORD_W];
  assign d = vars_i[wordHi(3, WORD_W) -: WORD_W];
  assign e = vars_i[wordHi(4, WORD_W) -: WORD_W];
  assign f = vars_i[wordHi(5, WORD_W) -: WORD_W];
  assign g = vars_i[wordHi(6, WORD_W) -: WORD_W];
  assign h = vars_i[wordHi(7, WORD_W) -: WORD_W];

  // Round datapath; sigmas evaluated at 64 bits then truncated to the word
  always_comb begin
    sig0   = WORD_W'(bigSigma0(64'(a), WORD_W));
    sig1   = WORD_W'(bigSigma1(64'(e), WORD_W));
    ch     = (e & f) ^ (~e & g);
    maj    = (a & b) ^ (a & c) ^ (b & c);
    t1     = h + sig1 + ch + kw_i;
    t2     = sig0 + maj;
    vars_o = {t1 + t2, a, b, c, d + t1, e, f, g};
  end
endmodule

// File: rtl/sha2_state_regs.sv
// SHA-2 state register bank: hash words H0..H7, working variables a..h,
// round counter and the IDLE/LOAD/ROUND/FINAL controller.
module sha2_state_regs
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input logic             clk,
  input logic             rst_n,
  sha2_state_regs_if.slave bus
);
  localparam int RW = $clog2(ROUNDS);
  localparam int VW = 8 * WORD_W;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : gIllegalWidth
    $error("sha2_state_regs: WORD_W must be 32 or 64");
  end

  state_e        state_q;
  logic          firstBlock_q;
  logic          busy_q;
  logic          done_q;
  logic [RW-1:0] round_q;
  logic [VW-1:0] hash_q;
  logic [VW-1:0] vars_q;
  logic [VW-1:0] vars_d;
  logic [VW-1:0] hashSum_d;

  sha2_round #(.WORD_W(WORD_W)) uRound (
    .vars_i (vars_q),
    .kw_i   (bus.kw_i),
    .vars_o (vars_d)
  );

  // Feed-forward sum H_i + var_i applied when the block finishes
  always_comb begin
    hashSum_d = '0;
    for (int i = 0; i < 8; i++) begin
      hashSum_d[wordHi(i, WORD_W) -: WORD_W] =
        hash_q[wordHi(i, WORD_W) -: WORD_W] + vars_q[wordHi(i, WORD_W) -: WORD_W];
    end
  end

  // Controller, counter and all state registers; reset discards any partial block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      firstBlock_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      round_q      <= '0;
      hash_q       <= '0;
      vars_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            firstBlock_q <= bus.first_block;
            busy_q       <= 1'b1;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          if (firstBlock_q) begin
            hash_q <= bus.iv_i;
            vars_q <= bus.iv_i;
          end else begin
            vars_q <= hash_q;
          end
          round_q <= '0;
          state_q <= ROUND;
        end
        ROUND: begin
          if (bus.kw_valid_i) begin
            vars_q <= vars_d;
            if (round_q == LAST_ROUND) begin
              round_q <= '0;
              state_q <= FINAL;
            end else begin
              round_q <= round_q + RW'(1);
            end
          end
        end
        FINAL: begin
          hash_q  <= hashSum_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.round_o  = round_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.digest_o = hash_q;
endmodule
